// File: rtl/cube_pow_if.sv
// Operand/result handshake bundle for cube_pow: start/busy request plus operand and cube result.
interface cube_pow_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   x_bi;
    logic               start_i;
    logic               busy_o;
    logic [3*WIDTH-1:0] y_bo;

    modport master (
        output x_bi,
        output start_i,
        input  busy_o,
        input  y_bo
    );

    modport slave (
        input  x_bi,
        input  start_i,
        output busy_o,
        output y_bo
    );
endinterface

// File: rtl/cube_pow.sv
// Sequential integer cube y = x^3 using one shift-add multiplier reused over two passes.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i, y_bo holds last result
// MUL1  | accumulating a*a, one multiplier bit per cycle, LSB first
// MUL2  | accumulating (a*a)*a, result written on the last bit
module cube_pow #(
    parameter int WIDTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    cube_pow_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ACC_W = 3 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL1 = 2'd1;
    localparam logic [1:0] MUL2 = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] sq_q, sq_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   y_q, y_d;

    logic               mul_bit;
    logic               last_bit;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_sum;

    // The multiplicand switches from a to a*a between passes; the multiplier is always a.
    always_comb begin
        mul_bit  = a_q[cnt_q];
        last_bit = (cnt_q == LAST_CNT);
        if (state_q == MUL2) begin
            addend = {{WIDTH{1'b0}}, sq_q} << cnt_q;
        end else begin
            addend = {{(2*WIDTH){1'b0}}, a_q} << cnt_q;
        end
        acc_sum = acc_q + (mul_bit ? addend : {ACC_W{1'b0}});
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    a_d     = bus.x_bi;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL1;
                end
            end
            MUL1: begin
                if (last_bit) begin
                    sq_d    = acc_sum[2*WIDTH-1:0];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL2;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MUL2: begin
                if (last_bit) begin
                    y_d     = acc_sum;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.y_bo   = y_q;
endmodule

// File: doc/cube_pow.md
Name: cube_pow

Overview:
- Sequential integer cube unit: computes y = x*x*x for an unsigned WIDTH-bit operand.
- Forward-direction counterpart of the cube-root block `cube`. Produces test operands for `cube` and checks round trips: cube_pow(cube(x)) ≤ x.
- Uses a single shift-add multiplier datapath reused across two passes: x*x, then (x*x)*x.
- Handshake is start_i / busy_o, the same as `cube`, so both blocks drop into the same bench and controller.

Parameters:
- WIDTH, 8, operand width in bits; result width is 3*WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- x_bi  input  WIDTH  unsigned operand; sampled only on the accepting edge.
- start_i  input  1  request; accepted only when idle.
- busy_o  output  1  high while a computation is in progress.
- y_bo  output  3*WIDTH  unsigned result x^3; holds the last completed value.

Behaviour:
- Reset (rst_i=1 at a rising edge): state IDLE, busy_o=0, y_bo=0, all internal registers 0.
  - Reset has priority over everything, including start_i in the same cycle.
  - Reset mid-operation aborts the computation; no partial result is written to y_bo.
- States: IDLE, MUL1, MUL2.
- IDLE:
  - busy_o=0.
  - On an edge with start_i=1: latch a_r<=x_bi, clear accumulator acc<=0 and bit counter cnt<=0, go to MUL1.
  - busy_o=1 from that edge onward.
- MUL1 computes sq = a_r*a_r, 2*WIDTH bits, one multiplier bit per cycle, LSB first:
  - if a_r[cnt] is set, acc += a_r << cnt; then cnt++.
  - After WIDTH cycles (cnt == WIDTH-1 on the edge): sq_r <= final acc, acc<=0, cnt<=0, go to MUL2.
- MUL2 computes sq_r*a_r, 3*WIDTH bits:
  - if a_r[cnt] is set, acc += sq_r << cnt; then cnt++.
  - On the WIDTH-th MUL2 edge: y_bo <= final acc (including the last partial product), busy_o<=0, go to IDLE.
- Latency: with start accepted at edge 0, busy_o is high after edges 0 through 2*WIDTH-1.
  - On edge 2*WIDTH, y_bo updates and busy_o falls together.
  - Total: 2*WIDTH busy cycles, which is 16 for WIDTH=8.
- Adder/accumulator width is 3*WIDTH. No overflow is possible: (2^WIDTH-1)^3 < 2^(3*WIDTH).
- start_i while busy_o=1: ignored, not queued.
- x_bi changes while busy: no effect; only the latched a_r is used.
- start_i held high continuously:
  - After completion the block spends exactly one cycle in IDLE (busy_o=0, new y_bo visible).
  - It then accepts the new x_bi on the next edge.
- y_bo changes only on a completion edge or on reset; it stays stable at all other times.
- Operand 0: the full 2*WIDTH-cycle sequence still runs; result 0. There is no early-exit path.

Test Plan:
1. Reset, then for x = 0..6 (WIDTH=8): pulse start_i for one cycle, wait until busy_o falls -> y_bo = 0, 1, 8, 27, 64, 125, 216. busy_o high for exactly 16 cycles each time.
2. x=255 -> y_bo = 16581375 (0xFD02FF) after 16 busy cycles. Also x=128 -> 2097152.
3. Start x=5. On busy cycle 3, drive x_bi=9 and pulse start_i -> y_bo=125 and busy_o drops at cycle 16. No second operation starts.
4. Start x=7 (previous y_bo=216). Assert rst_i on busy cycle 8 -> next edge busy_o=0, y_bo=0. Afterwards, x=3 with start -> 27.
5. Hold start_i=1 with x_bi=2, then 3 -> results 8 then 27. Exactly one busy_o=0 cycle between the operations; y_bo=8 is visible during that cycle.
6. Round trip with `cube`: for each x_c in {0, 1, 27, 100, 255}, compute r = cube(x_c), then cube_pow(r) -> result ≤ x_c and (r+1)^3 > x_c.
